// File: rtl/shift_ctrl_pkg.sv
// Shared definitions for the shift register command sequencer.
//   op_e     : command operation codes (3-bit field, codes 6 and 7 are unused)
//   SEL_*    : select encodings of the 4-bit universal shift register
//   state_e  : sequencer states
//   op_is_shift() : true for the five shift/rotate operations
package shift_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_LOAD = 3'd0,
    OP_SHR  = 3'd1,
    OP_SHL  = 3'd2,
    OP_ROR  = 3'd3,
    OP_ROL  = 3'd4,
    OP_ASR  = 3'd5
  } op_e;

  localparam logic [1:0] SEL_HOLD = 2'b00;
  localparam logic [1:0] SEL_SHR  = 2'b01;
  localparam logic [1:0] SEL_SHL  = 2'b10;
  localparam logic [1:0] SEL_LOAD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic logic op_is_shift(input logic [2:0] op);
    return (op >= 3'd1) && (op <= 3'd5);
  endfunction

endpackage

// File: rtl/shift_reg_controller.sv
// Command sequencer for a universal shift register (select 00 hold,
// 01 shift right, 10 shift left, 11 parallel load).
//
// Ports
//   CLK, Clear          : clock, asynchronous active-high reset
//   cmd_valid/cmd_ready : command handshake, accepted when both are high
//   cmd_op              : LOAD/SHR/SHL/ROR/ROL/ASR (6,7 complete with no action)
//   cmd_amount          : shift count, ignored for LOAD
//   cmd_data            : parallel load value
//   cmd_fill            : serial fill bit for SHR/SHL
//   stall               : pauses an in-progress shift
//   A_par               : register parallel output, feedback for rotate/ASR
//   s1, s0              : register select
//   MSB_in, LSB_in      : register serial inputs
//   I_par               : register parallel input
//   busy                : sequencer not idle
//   done                : one-cycle completion pulse
//
// state  | meaning
// IDLE   | waiting for a command, select hold
// LOAD   | parallel load of the latched data, one cycle
// SHIFT  | shifting, down-counter holds remaining shift edges
// DONE   | completion pulse, select hold
module shift_reg_controller
  import shift_ctrl_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             CLK,
  input  logic             Clear,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_amount,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_fill,
  input  logic             stall,
  input  logic [WIDTH-1:0] A_par,
  output logic             s1,
  output logic             s0,
  output logic             MSB_in,
  output logic             LSB_in,
  output logic [WIDTH-1:0] I_par,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             fill_q, fill_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             accept;
  logic [1:0]       sel;
  logic             msb_in_c;
  logic             lsb_in_c;
  logic [WIDTH-1:0] i_par_c;

  // Only the end bits of A_par feed back; the rest is intentionally unused.
  logic             unused_par;
  assign unused_par = ^A_par;

  // Ready drops immediately while Clear is held, independent of the state flop.
  assign cmd_ready = (state_q == ST_IDLE) && !Clear;
  assign accept    = cmd_valid && cmd_ready;

  // Next-state and latched-field computation.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    fill_d  = fill_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d   = cmd_op;
          cnt_d  = cmd_amount;
          data_d = cmd_data;
          fill_d = cmd_fill;
          if (cmd_op == OP_LOAD) begin
            state_d = ST_LOAD;
          end else if (op_is_shift(cmd_op) && (cmd_amount != '0)) begin
            state_d = ST_SHIFT;
          end else begin
            // zero amount or unused op code: report completion only
            state_d = ST_DONE;
          end
        end
      end
      ST_LOAD: begin
        state_d = ST_DONE;
      end
      ST_SHIFT: begin
        if (!stall) begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge CLK or posedge Clear) begin
    if (Clear) begin
      state_q <= ST_IDLE;
      op_q    <= 3'd0;
      cnt_q   <= '0;
      data_q  <= '0;
      fill_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      fill_q  <= fill_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Register pin decode. Select depends on state, latched op and stall;
  // the serial inputs take A_par combinationally so a rotate sees the value
  // the register holds at the edge it shifts on.
  always_comb begin
    sel      = SEL_HOLD;
    msb_in_c = 1'b0;
    lsb_in_c = 1'b0;
    i_par_c  = '0;

    case (state_q)
      ST_LOAD: begin
        sel     = SEL_LOAD;
        i_par_c = data_q;
      end
      ST_SHIFT: begin
        case (op_q)
          OP_SHR: begin
            sel      = SEL_SHR;
            msb_in_c = fill_q;
          end
          OP_SHL: begin
            sel      = SEL_SHL;
            lsb_in_c = fill_q;
          end
          OP_ROR: begin
            sel      = SEL_SHR;
            msb_in_c = A_par[0];
          end
          OP_ROL: begin
            sel      = SEL_SHL;
            lsb_in_c = A_par[WIDTH-1];
          end
          OP_ASR: begin
            sel      = SEL_SHR;
            msb_in_c = A_par[WIDTH-1];
          end
          default: begin
            sel = SEL_HOLD;
          end
        endcase
        if (stall) begin
          sel = SEL_HOLD;
        end
      end
      default: begin
        sel = SEL_HOLD;
      end
    endcase
  end

  assign s1     = sel[1];
  assign s0     = sel[0];
  assign MSB_in = msb_in_c;
  assign LSB_in = lsb_in_c;
  assign I_par  = i_par_c;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_shift_reg_controller.sv
// Bench for shift_reg_controller driving a behavioural 4-bit universal
// shift register. Expected register contents come from plain arithmetic on
// the operation; expected done timing from the shift count plus stall cycles.
module tb_shift_reg_controller;
  import shift_ctrl_pkg::*;

  localparam int WIDTH = 4;
  localparam int CNT_W = 3;

  logic             CLK = 1'b0;
  logic             Clear = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [2:0]       cmd_op = 3'd0;
  logic [CNT_W-1:0] cmd_amount = '0;
  logic [WIDTH-1:0] cmd_data = '0;
  logic             cmd_fill = 1'b0;
  logic             stall = 1'b0;
  logic [WIDTH-1:0] a_q;
  logic             s1, s0, MSB_in, LSB_in;
  logic [WIDTH-1:0] I_par;
  logic             busy, done;

  // The register is only cleared at power-on so that a mid-operation
  // controller reset leaves its partially shifted contents visible.
  logic             por = 1'b1;
  logic             clear_b;
  assign clear_b = ~(Clear & por);

  int n_vec = 0;
  int n_err = 0;
  int obs_shifts = 0;

  always #5 CLK = ~CLK;

  shift_reg_controller #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .CLK       (CLK),
    .Clear     (Clear),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_amount(cmd_amount),
    .cmd_data  (cmd_data),
    .cmd_fill  (cmd_fill),
    .stall     (stall),
    .A_par     (a_q),
    .s1        (s1),
    .s0        (s0),
    .MSB_in    (MSB_in),
    .LSB_in    (LSB_in),
    .I_par     (I_par),
    .busy      (busy),
    .done      (done)
  );

  // Universal shift register: 00 hold, 01 right, 10 left, 11 load.
  always_ff @(posedge CLK or negedge clear_b) begin
    if (!clear_b) a_q <= '0;
    else begin
      case ({s1, s0})
        2'b01:   a_q <= {MSB_in, a_q[WIDTH-1:1]};
        2'b10:   a_q <= {a_q[WIDTH-2:0], LSB_in};
        2'b11:   a_q <= I_par;
        default: a_q <= a_q;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Final register value after an operation, from the arithmetic meaning of each op.
  function automatic logic [3:0] ref_val(input logic [2:0] op, input int k,
                                         input logic [3:0] st, input logic [3:0] data,
                                         input logic fill);
    int v, r, s;
    v = int'(st);
    r = v;
    if (op == 3'd0) r = int'(data);
    else if (k != 0) begin
      case (op)
        3'd1: r = (v >> k) | (fill ? (15 ^ (15 >> k)) : 0);
        3'd2: r = (v << k) | (fill ? ((1 << k) - 1) : 0);
        3'd3: r = (v >> (k % 4)) | (v << (4 - (k % 4)));
        3'd4: r = (v << (k % 4)) | (v >> (4 - (k % 4)));
        3'd5: begin
          s = (v >= 8) ? v - 16 : v;
          r = s >>> k;
        end
        default: r = v;
      endcase
    end
    return 4'(r & 15);
  endfunction

  // Issue one command at the current (post-negedge) point and follow it to
  // the first idle cycle. smask bit j raises stall for cycle j after accept.
  task automatic run_cmd(input logic [2:0] op, input logic [CNT_W-1:0] amt,
                         input logic [3:0] data, input logic fill, input logic [31:0] smask);
    logic [3:0] exp_v;
    logic       shifting;
    logic [1:0] dir;
    logic       exp_msb, exp_lsb;
    int         done_at, rem, j;

    exp_v    = ref_val(op, int'(amt), a_q, data, fill);
    shifting = (op >= 3'd1) && (op <= 3'd5) && (amt != '0);
    dir      = (op == 3'd2 || op == 3'd4) ? 2'b10 : 2'b01;
    if (op == 3'd0) done_at = 1;
    else if (!shifting) done_at = 0;
    else begin
      rem = int'(amt);
      j = 0;
      while (rem > 0) begin
        if (j > 31 || !smask[j]) rem--;
        j++;
      end
      done_at = j;
    end

    chk("ready_idle", 32'(cmd_ready), 1);
    cmd_valid  = 1'b1;
    cmd_op     = op;
    cmd_amount = amt;
    cmd_data   = data;
    cmd_fill   = fill;
    stall      = 1'b0;
    @(posedge CLK);
    for (int s = 0; s <= done_at + 1; s++) begin
      @(negedge CLK);
      // scramble inputs so only latched values can be in use
      cmd_valid = 1'b0;
      cmd_data  = ~data;
      cmd_fill  = ~fill;
      stall     = (s < 32) ? smask[s] : 1'b0;
      #1;
      if (s < done_at) begin
        chk("done_low", 32'(done), 0);
        chk("busy_run", 32'(busy), 1);
        chk("ready_run", 32'(cmd_ready), 0);
        if (op == 3'd0) begin
          chk("sel_load", 32'({s1, s0}), 3);
          chk("i_par", 32'(I_par), 32'(data));
        end else begin
          chk("sel_shift", 32'({s1, s0}), stall ? 32'd0 : 32'(dir));
          if ({s1, s0} != 2'b00) obs_shifts++;
          if (!stall) begin
            exp_msb = 1'b0;
            exp_lsb = 1'b0;
            case (op)
              3'd1: exp_msb = fill;
              3'd2: exp_lsb = fill;
              3'd3: exp_msb = a_q[0];
              3'd4: exp_lsb = a_q[3];
              3'd5: exp_msb = a_q[3];
              default: ;
            endcase
            chk("msb_in", 32'(MSB_in), 32'(exp_msb));
            chk("lsb_in", 32'(LSB_in), 32'(exp_lsb));
          end
        end
      end else if (s == done_at) begin
        chk("done_pulse", 32'(done), 1);
        chk("sel_done", 32'({s1, s0}), 0);
        chk("busy_done", 32'(busy), 1);
        chk("ready_done", 32'(cmd_ready), 0);
        chk("reg_value", 32'(a_q), 32'(exp_v));
      end else begin
        chk("done_clear", 32'(done), 0);
        chk("busy_idle", 32'(busy), 0);
        chk("sel_idle", 32'({s1, s0}), 0);
        chk("ready_back", 32'(cmd_ready), 1);
      end
    end
    stall = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]       r_op;
    logic [CNT_W-1:0] r_amt;
    logic [3:0]       r_data;
    logic             r_fill;
    logic [31:0]      r_mask;

    // reset
    repeat (2) @(negedge CLK);
    #1;
    chk("rst_ready", 32'(cmd_ready), 0);
    chk("rst_sel", 32'({s1, s0}), 0);
    chk("rst_serial", 32'({MSB_in, LSB_in}), 0);
    chk("rst_ipar", 32'(I_par), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    @(negedge CLK);
    Clear = 1'b0;
    por   = 1'b0;
    #1;
    chk("rst_release_ready", 32'(cmd_ready), 1);

    // LOAD 1011
    run_cmd(3'd0, 3'd0, 4'b1011, 1'b0, 32'd0);
    chk("plan_load", 32'(a_q), 32'b1011);
    // ROR 1, ROL 2
    run_cmd(3'd3, 3'd1, 4'h0, 1'b0, 32'd0);
    chk("plan_ror1", 32'(a_q), 32'b1101);
    run_cmd(3'd4, 3'd2, 4'h0, 1'b0, 32'd0);
    chk("plan_rol2", 32'(a_q), 32'b0111);
    // ASR 3 of 1000
    run_cmd(3'd0, 3'd0, 4'b1000, 1'b0, 32'd0);
    run_cmd(3'd5, 3'd3, 4'h0, 1'b0, 32'd0);
    chk("plan_asr3", 32'(a_q), 32'b1111);
    // SHL 5 fill 0 of 1011, five shift edges
    run_cmd(3'd0, 3'd0, 4'b1011, 1'b0, 32'd0);
    obs_shifts = 0;
    run_cmd(3'd2, 3'd5, 4'h0, 1'b0, 32'd0);
    chk("plan_shl5", 32'(a_q), 32'b0000);
    chk("plan_shl5_edges", 32'(obs_shifts), 5);
    // SHR 3 fill 1 with two stall cycles mid-shift
    run_cmd(3'd0, 3'd0, 4'b0000, 1'b0, 32'd0);
    run_cmd(3'd1, 3'd3, 4'h0, 1'b1, 32'b0110);
    chk("plan_shr_stall", 32'(a_q), 32'b1110);
    // amount 0 and unused op code
    run_cmd(3'd0, 3'd0, 4'b1010, 1'b0, 32'd0);
    run_cmd(3'd1, 3'd0, 4'h0, 1'b1, 32'd0);
    run_cmd(3'd7, 3'd5, 4'h5, 1'b1, 32'd0);
    run_cmd(3'd6, 3'd2, 4'h5, 1'b0, 32'd0);
    chk("plan_noop", 32'(a_q), 32'b1010);

    // Clear during the second shift of a 4-shift ROR
    run_cmd(3'd0, 3'd0, 4'b1011, 1'b0, 32'd0);
    cmd_valid  = 1'b1;
    cmd_op     = 3'd3;
    cmd_amount = 3'd4;
    @(posedge CLK);
    @(negedge CLK);
    cmd_valid = 1'b0;
    @(negedge CLK);
    Clear = 1'b1;
    #1;
    chk("clr_sel", 32'({s1, s0}), 0);
    chk("clr_serial", 32'({MSB_in, LSB_in}), 0);
    chk("clr_busy", 32'(busy), 0);
    chk("clr_done", 32'(done), 0);
    chk("clr_ready", 32'(cmd_ready), 0);
    @(negedge CLK);
    #1;
    chk("clr_done_hold", 32'(done), 0);
    chk("clr_reg_partial", 32'(a_q), 32'b1101);
    Clear = 1'b0;
    #1;
    chk("clr_release_ready", 32'(cmd_ready), 1);
    chk("clr_release_done", 32'(done), 0);
    run_cmd(3'd0, 3'd0, 4'b0110, 1'b0, 32'd0);
    chk("clr_next_load", 32'(a_q), 32'b0110);

    // random commands with sparse stalls
    for (int n = 0; n < 40; n++) begin
      r_op   = 3'($urandom_range(0, 7));
      r_amt  = CNT_W'($urandom_range(0, 7));
      r_data = 4'($urandom);
      r_fill = 1'($urandom);
      r_mask = $urandom & $urandom & $urandom;
      run_cmd(r_op, r_amt, r_data, r_fill, r_mask);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
